// File: rtl/phys_reg_file_pkg.sv
// Shared core package for the physical register file.
// Holds the default geometry (register count, index width, data width)
// and the physical-register index / data typedefs used by the core.
package phys_reg_file_pkg;

  localparam int NUM_PREGS = 64;
  localparam int PREG_W    = 6;
  localparam int XLEN      = 32;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [XLEN-1:0]   xdata_t;

endpackage

// File: rtl/phys_reg_file_preg_ready_table.sv
// preg_ready_table: one ready bit per physical register.
//   - alloc clears a bit, writeback sets it, flush sets every bit.
//   - alloc beats writeback on the same preg; flush beats alloc.
//   - preg 0 is hard-wired ready.
//   - queries see same-cycle writebacks, but not same-cycle allocs.
// Ports:
//   clk, rst            clock, synchronous active-high reset (all ready)
//   flush               discard speculative allocations
//   wb0_*/wb1_*         writeback valid + destination index
//   alloc_valid/preg    rename allocation
//   qry1/2_preg         readiness query indices
//   qry1/2_ready        combinational readiness answers
module preg_ready_table
  import phys_reg_file_pkg::*;
#(
  parameter int NUM_PREGS = phys_reg_file_pkg::NUM_PREGS,
  parameter int PREG_W    = phys_reg_file_pkg::PREG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wb0_valid,
  input  logic [PREG_W-1:0] wb0_preg,
  input  logic              wb1_valid,
  input  logic [PREG_W-1:0] wb1_preg,
  input  logic              alloc_valid,
  input  logic [PREG_W-1:0] alloc_preg,
  input  logic [PREG_W-1:0] qry1_preg,
  input  logic [PREG_W-1:0] qry2_preg,
  output logic              qry1_ready,
  output logic              qry2_ready
);

  logic [NUM_PREGS-1:0] ready;
  logic [NUM_PREGS-1:0] ready_next;

  // Next-state ready vector with priority flush > alloc > writeback > hold.
  always_comb begin
    ready_next = ready;
    for (int i = 0; i < NUM_PREGS; i++) begin
      if (i == 0 || flush) begin
        ready_next[i] = 1'b1;
      end else if (alloc_valid && alloc_preg == PREG_W'(i)) begin
        ready_next[i] = 1'b0;
      end else if ((wb0_valid && wb0_preg == PREG_W'(i)) ||
                   (wb1_valid && wb1_preg == PREG_W'(i))) begin
        ready_next[i] = 1'b1;
      end else begin
        ready_next[i] = ready[i];
      end
    end
  end

  // Ready vector register; reset marks every preg ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready <= {NUM_PREGS{1'b1}};
    end else begin
      ready <= ready_next;
    end
  end

  // Query answers: stored bit, or a writeback landing this cycle.
  always_comb begin
    qry1_ready = ready[qry1_preg] ||
                 (wb0_valid && wb0_preg == qry1_preg) ||
                 (wb1_valid && wb1_preg == qry1_preg);
    qry2_ready = ready[qry2_preg] ||
                 (wb0_valid && wb0_preg == qry2_preg) ||
                 (wb1_valid && wb1_preg == qry2_preg);
  end

endmodule

// File: rtl/phys_reg_file.sv
// phys_reg_file: physical register file with two read ports, two
// writeback ports and a readiness scoreboard for the scheduler.
//   - reads and queries are combinational and bypass same-cycle writebacks
//   - writes land at the next posedge; wb1 wins over wb0 on the same preg
//   - preg 0 reads as zero and ignores writes
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   src1/2_reg, src1/2_val read port index / data (register read stage)
//   wb0_*, wb1_*           writeback valid / index / data
//   alloc_valid/preg       rename allocation (clears readiness)
//   qry1/2_preg, _ready    scheduler readiness queries
//   flush                  mark all pregs ready (data untouched)
module phys_reg_file
  import phys_reg_file_pkg::*;
#(
  parameter int NUM_PREGS = phys_reg_file_pkg::NUM_PREGS,
  parameter int PREG_W    = phys_reg_file_pkg::PREG_W,
  parameter int XLEN      = phys_reg_file_pkg::XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PREG_W-1:0] src1_reg,
  input  logic [PREG_W-1:0] src2_reg,
  output logic [XLEN-1:0]   src1_val,
  output logic [XLEN-1:0]   src2_val,
  input  logic              wb0_valid,
  input  logic [PREG_W-1:0] wb0_preg,
  input  logic [XLEN-1:0]   wb0_data,
  input  logic              wb1_valid,
  input  logic [PREG_W-1:0] wb1_preg,
  input  logic [XLEN-1:0]   wb1_data,
  input  logic              alloc_valid,
  input  logic [PREG_W-1:0] alloc_preg,
  input  logic [PREG_W-1:0] qry1_preg,
  input  logic [PREG_W-1:0] qry2_preg,
  output logic              qry1_ready,
  output logic              qry2_ready,
  input  logic              flush
);

  logic [XLEN-1:0] regs [NUM_PREGS];

  // Read with bypass: zero for preg 0, then wb1, then wb0, then storage.
  function automatic logic [XLEN-1:0] read_port(input logic [PREG_W-1:0] idx);
    logic [XLEN-1:0] val;
    if (idx == {PREG_W{1'b0}}) begin
      val = {XLEN{1'b0}};
    end else if (wb1_valid && wb1_preg == idx) begin
      val = wb1_data;
    end else if (wb0_valid && wb0_preg == idx) begin
      val = wb0_data;
    end else begin
      val = regs[idx];
    end
    return val;
  endfunction

  // Data array: reset clears everything; wb1 is issued last so it wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        regs[i] <= {XLEN{1'b0}};
      end
    end else begin
      if (wb0_valid && wb0_preg != {PREG_W{1'b0}}) begin
        regs[wb0_preg] <= wb0_data;
      end
      if (wb1_valid && wb1_preg != {PREG_W{1'b0}}) begin
        regs[wb1_preg] <= wb1_data;
      end
    end
  end

  // Combinational read ports.
  always_comb begin
    src1_val = read_port(src1_reg);
    src2_val = read_port(src2_reg);
  end

  preg_ready_table #(
    .NUM_PREGS (NUM_PREGS),
    .PREG_W    (PREG_W)
  ) u_ready (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wb0_valid   (wb0_valid),
    .wb0_preg    (wb0_preg),
    .wb1_valid   (wb1_valid),
    .wb1_preg    (wb1_preg),
    .alloc_valid (alloc_valid),
    .alloc_preg  (alloc_preg),
    .qry1_preg   (qry1_preg),
    .qry2_preg   (qry2_preg),
    .qry1_ready  (qry1_ready),
    .qry2_ready  (qry2_ready)
  );

endmodule

// File: tb/tb_phys_reg_file.sv
// Directed bench for phys_reg_file. Stimulus cycles push hand-computed
// expectations into a queue; a monitor on the falling edge pops and
// compares them against the combinational outputs of that cycle.
module tb_phys_reg_file;

  logic        clk;
  logic        rst;
  logic [5:0]  src1_reg, src2_reg;
  logic [31:0] src1_val, src2_val;
  logic        wb0_valid, wb1_valid;
  logic [5:0]  wb0_preg, wb1_preg;
  logic [31:0] wb0_data, wb1_data;
  logic        alloc_valid;
  logic [5:0]  alloc_preg;
  logic [5:0]  qry1_preg, qry2_preg;
  logic        qry1_ready, qry2_ready;
  logic        flush;

  int n_pass  = 0;
  int n_total = 0;

  string       q_name [$];
  int          q_sel  [$];
  logic [31:0] q_val  [$];

  localparam int SEL_SRC1 = 0;
  localparam int SEL_SRC2 = 1;
  localparam int SEL_QRY1 = 2;
  localparam int SEL_QRY2 = 3;

  phys_reg_file dut (
    .clk         (clk),
    .rst         (rst),
    .src1_reg    (src1_reg),
    .src2_reg    (src2_reg),
    .src1_val    (src1_val),
    .src2_val    (src2_val),
    .wb0_valid   (wb0_valid),
    .wb0_preg    (wb0_preg),
    .wb0_data    (wb0_data),
    .wb1_valid   (wb1_valid),
    .wb1_preg    (wb1_preg),
    .wb1_data    (wb1_data),
    .alloc_valid (alloc_valid),
    .alloc_preg  (alloc_preg),
    .qry1_preg   (qry1_preg),
    .qry2_preg   (qry2_preg),
    .qry1_ready  (qry1_ready),
    .qry2_ready  (qry2_ready),
    .flush       (flush)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clear_inputs();
    rst = 1'b0; flush = 1'b0;
    src1_reg = 6'd0; src2_reg = 6'd0;
    wb0_valid = 1'b0; wb0_preg = 6'd0; wb0_data = 32'd0;
    wb1_valid = 1'b0; wb1_preg = 6'd0; wb1_data = 32'd0;
    alloc_valid = 1'b0; alloc_preg = 6'd0;
    qry1_preg = 6'd0; qry2_preg = 6'd0;
  endtask

  // Start a new stimulus cycle just after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic expect_out(input string nm, input int sel, input logic [31:0] v);
    q_name.push_back(nm);
    q_sel.push_back(sel);
    q_val.push_back(v);
  endtask

  // Monitor: compare every queued expectation on the falling edge.
  initial begin
    string       nm;
    int          sel;
    logic [31:0] exp_v;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (q_sel.size() > 0) begin
        nm    = q_name.pop_front();
        sel   = q_sel.pop_front();
        exp_v = q_val.pop_front();
        case (sel)
          SEL_SRC1: act = src1_val;
          SEL_SRC2: act = src2_val;
          SEL_QRY1: act = {31'd0, qry1_ready};
          SEL_QRY2: act = {31'd0, qry2_ready};
          default:  act = 32'hxxxx_xxxx;
        endcase
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp_v);
      end
    end
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);

    // After reset: data zero, everything ready.
    cyc(); src1_reg = 6'd5; qry1_preg = 6'd5; src2_reg = 6'd63; qry2_preg = 6'd63;
    expect_out("reset_src1_p5", SEL_SRC1, 32'd0);
    expect_out("reset_qry1_p5", SEL_QRY1, 32'd1);
    expect_out("reset_src2_p63", SEL_SRC2, 32'd0);
    expect_out("reset_qry2_p63", SEL_QRY2, 32'd1);

    // Alloc p7: not visible to queries in the same cycle.
    cyc(); alloc_valid = 1'b1; alloc_preg = 6'd7; qry1_preg = 6'd7;
    expect_out("alloc_same_cycle_qry", SEL_QRY1, 32'd1);

    cyc(); qry1_preg = 6'd7; src1_reg = 6'd7;
    expect_out("alloc_p7_not_ready", SEL_QRY1, 32'd0);
    expect_out("p7_data_before_wb", SEL_SRC1, 32'd0);

    cyc(); qry1_preg = 6'd7; src1_reg = 6'd7;
    wb0_valid = 1'b1; wb0_preg = 6'd7; wb0_data = 32'hDEADBEEF;
    expect_out("wb_bypass_qry_p7", SEL_QRY1, 32'd1);
    expect_out("wb_bypass_src_p7", SEL_SRC1, 32'hDEADBEEF);

    cyc(); qry1_preg = 6'd7; src1_reg = 6'd7;
    expect_out("p7_ready_persist", SEL_QRY1, 32'd1);
    expect_out("p7_data_persist", SEL_SRC1, 32'hDEADBEEF);

    // wb0 and wb1 to the same preg: wb1 wins.
    cyc(); src2_reg = 6'd9;
    wb0_valid = 1'b1; wb0_preg = 6'd9; wb0_data = 32'h11;
    wb1_valid = 1'b1; wb1_preg = 6'd9; wb1_data = 32'h22;
    expect_out("dual_wb_bypass", SEL_SRC2, 32'h22);

    cyc(); src2_reg = 6'd9; src1_reg = 6'd9;
    expect_out("dual_wb_stored_src2", SEL_SRC2, 32'h22);
    expect_out("dual_wb_stored_src1", SEL_SRC1, 32'h22);

    // Preg 0 ignores writes, reads zero, always ready.
    cyc(); src1_reg = 6'd0; qry1_preg = 6'd0;
    wb0_valid = 1'b1; wb0_preg = 6'd0; wb0_data = 32'hFFFFFFFF;
    expect_out("p0_no_bypass", SEL_SRC1, 32'd0);
    expect_out("p0_ready", SEL_QRY1, 32'd1);

    cyc(); src1_reg = 6'd0; qry2_preg = 6'd0;
    expect_out("p0_no_store", SEL_SRC1, 32'd0);
    expect_out("p0_ready_after", SEL_QRY2, 32'd1);

    // Alloc and wb1 to the same preg: alloc wins readiness, data written.
    cyc(); alloc_valid = 1'b1; alloc_preg = 6'd3; qry2_preg = 6'd3;
    wb1_valid = 1'b1; wb1_preg = 6'd3; wb1_data = 32'h55;
    expect_out("alloc_wb_same_qry_bypass", SEL_QRY2, 32'd1);

    cyc(); qry2_preg = 6'd3; src1_reg = 6'd3;
    expect_out("alloc_beats_wb_ready", SEL_QRY2, 32'd0);
    expect_out("alloc_wb_data_written", SEL_SRC1, 32'h55);

    // Flush restores readiness and overrides a same-cycle alloc.
    cyc(); alloc_valid = 1'b1; alloc_preg = 6'd4;
    cyc(); alloc_valid = 1'b1; alloc_preg = 6'd5; qry1_preg = 6'd4;
    expect_out("alloc_p4_not_ready", SEL_QRY1, 32'd0);

    cyc(); flush = 1'b1; alloc_valid = 1'b1; alloc_preg = 6'd6;
    qry1_preg = 6'd5; qry2_preg = 6'd4;
    wb0_valid = 1'b1; wb0_preg = 6'd10; wb0_data = 32'hA5;
    expect_out("flush_cycle_p5_not_ready", SEL_QRY1, 32'd0);
    expect_out("flush_cycle_p4_not_ready", SEL_QRY2, 32'd0);

    cyc(); qry1_preg = 6'd4; qry2_preg = 6'd5; src1_reg = 6'd10;
    expect_out("flush_p4_ready", SEL_QRY1, 32'd1);
    expect_out("flush_p5_ready", SEL_QRY2, 32'd1);
    expect_out("flush_wb_data_written", SEL_SRC1, 32'hA5);

    cyc(); qry1_preg = 6'd6; qry2_preg = 6'd3; src2_reg = 6'd7;
    expect_out("flush_beats_alloc_p6", SEL_QRY1, 32'd1);
    expect_out("flush_p3_ready", SEL_QRY2, 32'd1);
    expect_out("flush_keeps_data", SEL_SRC2, 32'hDEADBEEF);

    // Reset mid-sequence overrides wb and alloc.
    cyc(); alloc_valid = 1'b1; alloc_preg = 6'd8;
    wb0_valid = 1'b1; wb0_preg = 6'd11; wb0_data = 32'h77;

    cyc(); rst = 1'b1; qry1_preg = 6'd8; src1_reg = 6'd11; src2_reg = 6'd12;
    qry2_preg = 6'd13;
    wb0_valid = 1'b1; wb0_preg = 6'd12; wb0_data = 32'h99;
    alloc_valid = 1'b1; alloc_preg = 6'd13;
    expect_out("rst_cycle_p8_not_ready", SEL_QRY1, 32'd0);
    expect_out("rst_cycle_p11_data", SEL_SRC1, 32'h77);
    expect_out("rst_cycle_wb_bypass", SEL_SRC2, 32'h99);
    expect_out("rst_cycle_p13_ready", SEL_QRY2, 32'd1);

    cyc(); src1_reg = 6'd11; src2_reg = 6'd12; qry1_preg = 6'd8; qry2_preg = 6'd13;
    expect_out("post_rst_p11_zero", SEL_SRC1, 32'd0);
    expect_out("post_rst_p12_zero", SEL_SRC2, 32'd0);
    expect_out("post_rst_p8_ready", SEL_QRY1, 32'd1);
    expect_out("post_rst_p13_ready", SEL_QRY2, 32'd1);

    cyc(); src1_reg = 6'd21; src2_reg = 6'd20; qry1_preg = 6'd7;
    wb0_valid = 1'b1; wb0_preg = 6'd20; wb0_data = 32'h1234;
    expect_out("no_bypass_other_preg", SEL_SRC1, 32'd0);
    expect_out("bypass_p20", SEL_SRC2, 32'h1234);
    expect_out("post_rst_p7_ready", SEL_QRY1, 32'd1);

    cyc(); src1_reg = 6'd7; src2_reg = 6'd9;
    expect_out("post_rst_p7_zero", SEL_SRC1, 32'd0);
    expect_out("post_rst_p9_zero", SEL_SRC2, 32'd0);

    cyc();
    @(negedge clk);
    #1;
    if (q_sel.size() != 0) begin
      n_total++;
      $display("FAIL queue_drain: got %0d pending, expected 0", q_sel.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
